// File: rtl/dmem_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// dmem_pkg : shared types and constants for the data-memory responder
// Revision : 1.0
//------------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   typedef enum logic {
      OP_LOAD  = 1'b0,
      OP_STORE = 1'b1
   } dmem_op_e;

   // All-ones address; the responder slices it down to its own ADDR_W.
   localparam logic [31:0] DMEM_MMIO_CNT_OFS = 32'hFFFF_FFFF;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// dmem_responder_if : core data-memory bus (initiator = master, memory = slave)
// Revision : 1.0
//------------------------------------------------------------------------------
interface dmem_responder_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) ();
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] write_data;
   logic [DATA_W-1:0] read_data;
   logic              mem_ready;
   logic              busy;
   logic              err;

   modport master (
      output mem_read, mem_write, address, write_data,
      input  read_data, mem_ready, busy, err
   );

   modport slave (
      input  mem_read, mem_write, address, write_data,
      output read_data, mem_ready, busy, err
   );
endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_wait_timer.sv
`default_nettype none
//------------------------------------------------------------------------------
// dmem_wait_timer : loadable down-counter that times the wait states
// Revision : 1.0
//------------------------------------------------------------------------------
module dmem_wait_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   input  logic             count_en,
   output logic             done
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_value;
      end else if (count_en && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign done = (r_count == '0);

endmodule : dmem_wait_timer
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// dmem_responder : byte RAM target with programmable wait states and an
//                  optional cycle-counter register at the all-ones address
// Revision : 1.0
//------------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 8,
   parameter int WAIT_STATES = 2,
   parameter int MMIO_EN     = 1
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);
   localparam int                c_depth     = 1 << ADDR_W;
   localparam logic [3:0]        c_wait_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam logic [ADDR_W-1:0] c_mmio_addr = DMEM_MMIO_CNT_OFS[ADDR_W-1:0];

   dmem_state_e       r_state;
   dmem_state_e       w_next_state;
   dmem_op_e          r_op;
   dmem_op_e          w_req_op;
   dmem_op_e          w_resp_op;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] w_resp_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_read_data;
   logic [DATA_W-1:0] r_cycle_cnt;
   logic [DATA_W-1:0] r_mem [c_depth];
   logic              r_err;
   logic              w_accept;
   logic              w_enter_resp;
   logic              w_leave_store;
   logic              w_resp_mmio;
   logic              w_addr_q_mmio;
   logic              w_timer_en;
   logic              w_timer_done;

   assign w_accept    = (r_state == IDLE) && (bus.mem_read || bus.mem_write);
   assign w_req_op    = bus.mem_write ? OP_STORE : OP_LOAD;
   // With zero wait states RESP is entered from IDLE, before the latches hold the request.
   assign w_resp_op   = (r_state == IDLE) ? w_req_op    : r_op;
   assign w_resp_addr = (r_state == IDLE) ? bus.address : r_addr;
   assign w_enter_resp  = (w_next_state == RESP) && (r_state != RESP);
   assign w_leave_store = (r_state == RESP) && (r_op == OP_STORE);
   assign w_timer_en    = (r_state == WAIT);

   if (MMIO_EN != 0) begin : g_mmio
      assign w_resp_mmio   = (w_resp_addr == c_mmio_addr);
      assign w_addr_q_mmio = (r_addr == c_mmio_addr);
   end else begin : g_no_mmio
      assign w_resp_mmio   = 1'b0;
      assign w_addr_q_mmio = 1'b0;
   end

   dmem_wait_timer #(
      .CNT_W (4)
   ) u_wait_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (w_accept),
      .load_value (c_wait_load),
      .count_en   (w_timer_en),
      .done       (w_timer_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_next_state = (WAIT_STATES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (w_timer_done) begin
               w_next_state = RESP;
            end
         end
         RESP:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_ready = 1'b0;
      bus.busy      = 1'b0;
      case (r_state)
         WAIT: bus.busy = 1'b1;
         RESP: begin
            bus.busy      = 1'b1;
            bus.mem_ready = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.read_data = r_read_data;
   assign bus.err       = r_err;

   // Both strobes at acceptance resolve to a store and flag the protocol error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_op    <= OP_LOAD;
         r_addr  <= '0;
         r_wdata <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_op    <= w_req_op;
         r_addr  <= bus.address;
         r_wdata <= bus.write_data;
         if (bus.mem_read && bus.mem_write) begin
            r_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_read_data <= '0;
      end else if (w_enter_resp && (w_resp_op == OP_LOAD)) begin
         r_read_data <= w_resp_mmio ? r_cycle_cnt : r_mem[w_resp_addr];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cycle_cnt <= '0;
      end else if (w_leave_store && w_addr_q_mmio) begin
         r_cycle_cnt <= '0;
      end else begin
         r_cycle_cnt <= r_cycle_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < c_depth; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_leave_store && !w_addr_q_mmio) begin
         r_mem[r_addr] <= r_wdata;
      end
   end

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_dmem_responder : two responders (2 and 0 wait states) against a
//                     transaction-level timing/memory model
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_dmem_responder;
   localparam int N_DUT = 2;

   logic   clk   = 1'b0;
   logic   rst_n = 1'b1;
   int     tests = 0;
   int     fails = 0;
   longint edge_cnt = 0;

   logic       drv_rd    [N_DUT];
   logic       drv_wr    [N_DUT];
   logic [7:0] drv_addr  [N_DUT];
   logic [7:0] drv_wd    [N_DUT];
   logic [7:0] act_rdata [N_DUT];
   logic       act_ready [N_DUT];
   logic       act_busy  [N_DUT];
   logic       act_err   [N_DUT];

   dmem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus_a ();
   dmem_responder_if #(.DATA_W(8), .ADDR_W(8)) bus_b ();

   assign bus_a.mem_read   = drv_rd[0];
   assign bus_a.mem_write  = drv_wr[0];
   assign bus_a.address    = drv_addr[0];
   assign bus_a.write_data = drv_wd[0];
   assign act_rdata[0]     = bus_a.read_data;
   assign act_ready[0]     = bus_a.mem_ready;
   assign act_busy[0]      = bus_a.busy;
   assign act_err[0]       = bus_a.err;

   assign bus_b.mem_read   = drv_rd[1];
   assign bus_b.mem_write  = drv_wr[1];
   assign bus_b.address    = drv_addr[1];
   assign bus_b.write_data = drv_wd[1];
   assign act_rdata[1]     = bus_b.read_data;
   assign act_ready[1]     = bus_b.mem_ready;
   assign act_busy[1]      = bus_b.busy;
   assign act_err[1]       = bus_b.err;

   dmem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(2), .MMIO_EN(1)) dut_a (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus_a)
   );

   dmem_responder #(.DATA_W(8), .ADDR_W(8), .WAIT_STATES(0), .MMIO_EN(1)) dut_b (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   function automatic int ws_of(input int k);
      return (k == 0) ? 2 : 0;
   endfunction

   // Model: each accepted request is a transaction with a response edge.
   logic [7:0] m_mem   [N_DUT][256];
   logic [7:0] m_cnt   [N_DUT];
   logic [7:0] m_rdata [N_DUT];
   logic [7:0] m_addr  [N_DUT];
   logic [7:0] m_wd    [N_DUT];
   bit         m_err   [N_DUT];
   bit         m_pend  [N_DUT];
   bit         m_store [N_DUT];
   longint     m_resp_edge [N_DUT];

   task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s[dut%0d] got 0x%0h expected 0x%0h at t=%0t", name, k, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < N_DUT; k++) begin
         for (int a = 0; a < 256; a++) m_mem[k][a] = 8'h00;
         m_cnt[k]   = 8'h00;
         m_rdata[k] = 8'h00;
         m_err[k]   = 1'b0;
         m_pend[k]  = 1'b0;
         m_store[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k);
      bit         clr;
      logic [7:0] cnt_before;
      clr        = 1'b0;
      cnt_before = m_cnt[k];
      if (m_pend[k] && (edge_cnt == m_resp_edge[k] + 1)) begin
         if (m_store[k]) begin
            if (m_addr[k] == 8'hFF) clr = 1'b1;
            else                    m_mem[k][m_addr[k]] = m_wd[k];
         end
         m_pend[k] = 1'b0;
      end else if (!m_pend[k] && (drv_rd[k] || drv_wr[k])) begin
         m_pend[k]      = 1'b1;
         m_store[k]     = drv_wr[k];
         m_addr[k]      = drv_addr[k];
         m_wd[k]        = drv_wd[k];
         m_resp_edge[k] = edge_cnt + ws_of(k);
         if (drv_rd[k] && drv_wr[k]) m_err[k] = 1'b1;
      end
      if (m_pend[k] && (edge_cnt == m_resp_edge[k]) && !m_store[k]) begin
         m_rdata[k] = (m_addr[k] == 8'hFF) ? cnt_before : m_mem[k][m_addr[k]];
      end
      m_cnt[k] = clr ? 8'h00 : cnt_before + 8'h01;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         edge_cnt++;
         for (int k = 0; k < N_DUT; k++) model_step(k);
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < N_DUT; k++) begin
         chk("mem_ready", k, 32'(act_ready[k]), 32'(m_pend[k] && (edge_cnt == m_resp_edge[k])));
         chk("busy",      k, 32'(act_busy[k]),  32'(m_pend[k]));
         chk("err",       k, 32'(act_err[k]),   32'(m_err[k]));
         chk("read_data", k, 32'(act_rdata[k]), 32'(m_rdata[k]));
      end
   end

   task automatic req(input int k, input bit rd, input bit wr, input logic [7:0] addr,
                      input logic [7:0] wd, input bit scramble, input logic [7:0] scr_addr,
                      output int lat, output logic [7:0] data);
      drv_rd[k]   = rd;
      drv_wr[k]   = wr;
      drv_addr[k] = addr;
      drv_wd[k]   = wd;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (scramble && (lat == 1) && !act_ready[k]) begin
            drv_addr[k] = scr_addr;
            drv_wd[k]   = 8'($urandom);
         end
      end while (!act_ready[k] && (lat < 40));
      if (!act_ready[k]) begin
         tests++;
         fails++;
         $display("FAIL req_timeout[dut%0d] no mem_ready within %0d cycles, expected one", k, lat);
      end
      data = act_rdata[k];
      @(posedge clk); #1;
      drv_rd[k] = 1'b0;
      drv_wr[k] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int         lat;
      int         seen;
      int         sel;
      int         op;
      logic [7:0] d;
      logic [7:0] a;

      for (int k = 0; k < N_DUT; k++) begin
         drv_rd[k] = 1'b0; drv_wr[k] = 1'b0; drv_addr[k] = 8'h00; drv_wd[k] = 8'h00;
      end
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int k = 0; k < N_DUT; k++) begin
         chk("rst_ready", k, 32'(act_ready[k]), 32'd0);
         chk("rst_busy",  k, 32'(act_busy[k]),  32'd0);
         chk("rst_err",   k, 32'(act_err[k]),   32'd0);
         chk("rst_rdata", k, 32'(act_rdata[k]), 32'd0);
      end

      // Reset dropped mid-WAIT of a store must abort it without a response.
      drv_wr[0] = 1'b1; drv_addr[0] = 8'h10; drv_wd[0] = 8'hAA;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      drv_wr[0] = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b1;
      seen = 0;
      repeat (6) begin @(posedge clk); #1; if (act_ready[0]) seen++; end
      chk("abort_no_ready", 0, 32'(seen), 32'd0);
      req(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, lat, d);
      chk("abort_no_write", 0, 32'(d), 32'h00);

      req(0, 1'b0, 1'b1, 8'h05, 8'h3C, 1'b0, 8'h00, lat, d);
      chk("ws2_store_lat", 0, 32'(lat), 32'd3);
      req(0, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h00, lat, d);
      chk("ws2_load_lat", 0, 32'(lat), 32'd3);
      chk("ws2_load_data", 0, 32'(d), 32'h3C);

      // Zero wait states, request held across two back-to-back loads.
      req(1, 1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 8'h00, lat, d);
      chk("ws0_store_lat", 1, 32'(lat), 32'd1);
      req(1, 1'b0, 1'b1, 8'h01, 8'h22, 1'b0, 8'h00, lat, d);
      drv_rd[1] = 1'b1; drv_addr[1] = 8'h00;
      @(posedge clk); #1;
      chk("b2b_ready0", 1, 32'(act_ready[1]), 32'd1);
      chk("b2b_data0",  1, 32'(act_rdata[1]), 32'h11);
      drv_addr[1] = 8'h01;
      @(posedge clk); #1;
      chk("b2b_gap",    1, 32'(act_ready[1]), 32'd0);
      @(posedge clk); #1;
      chk("b2b_ready1", 1, 32'(act_ready[1]), 32'd1);
      chk("b2b_data1",  1, 32'(act_rdata[1]), 32'h22);
      @(posedge clk); #1;
      drv_rd[1] = 1'b0;

      req(0, 1'b1, 1'b1, 8'h20, 8'h55, 1'b0, 8'h00, lat, d);
      chk("both_err",       0, 32'(act_err[0]), 32'd1);
      chk("both_rdata_kept", 0, 32'(d), 32'h3C);
      req(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, lat, d);
      chk("both_stored", 0, 32'(d), 32'h55);
      chk("err_sticky",  0, 32'(act_err[0]), 32'd1);

      // Counter cleared at edge C; load accepted at C+6 reaches RESP at C+8, counter then 7.
      req(0, 1'b0, 1'b1, 8'hFF, 8'h99, 1'b0, 8'h00, lat, d);
      repeat (5) begin @(posedge clk); #1; end
      req(0, 1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'h00, lat, d);
      chk("mmio_count", 0, 32'(d), 32'h07);

      req(0, 1'b0, 1'b1, 8'h30, 8'hA5, 1'b0, 8'h00, lat, d);
      req(0, 1'b0, 1'b1, 8'h31, 8'h5A, 1'b0, 8'h00, lat, d);
      req(0, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 8'h31, lat, d);
      chk("latched_addr", 0, 32'(d), 32'hA5);
      chk("latched_lat",  0, 32'(lat), 32'd3);

      for (int k = 0; k < N_DUT; k++) begin
         for (int i = 0; i < 60; i++) begin
            op  = $urandom_range(0, 9);
            sel = $urandom_range(0, 3);
            if (sel < 2)       a = 8'($urandom_range(0, 7));
            else if (sel == 2) a = 8'hFF;
            else               a = 8'($urandom);
            req(k, (op < 4) || (op == 9), (op >= 4), a, 8'($urandom),
                1'($urandom_range(0, 1)), 8'($urandom), lat, d);
            chk("rand_lat", k, 32'(lat), 32'(ws_of(k) + 1));
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
      end

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_dmem_responder
`default_nettype wire
